// File: rtl/csa_stream_accumulator.sv
// Streaming multi-operand adder: carry-save accumulation of a batch of operands,
// then a chunked ripple-carry resolve of S+C presented on a valid/ready port.
module csa_stream_accumulator #(
   parameter int WIDTH   = 4,
   parameter int MAX_OPS = 16,
   parameter int CHUNK   = 4,
   localparam int ACC_W  = WIDTH + $clog2(MAX_OPS),
   localparam int CNT_W  = $clog2(MAX_OPS) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   localparam int NCHUNK = (ACC_W + CHUNK - 1) / CHUNK;
   localparam int PAD_W  = NCHUNK * CHUNK;
   localparam int RIDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   localparam logic [1:0] ACCUM   = 2'd0;
   localparam logic [1:0] RESOLVE = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   logic [1:0]        state;
   logic [ACC_W-1:0]  s_reg;
   logic [ACC_W-1:0]  c_reg;
   logic [CNT_W-1:0]  count;
   logic [RIDX_W-1:0] ridx;
   logic              carry;

   logic              accept;
   logic [ACC_W-1:0]  d_ext;
   logic [CNT_W-1:0]  cnt_next;
   logic [PAD_W-1:0]  s_pad;
   logic [PAD_W-1:0]  c_pad;
   logic [PAD_W-1:0]  sum_pad;
   logic [CHUNK:0]    chunk_sum;

   assign in_ready = (state == ACCUM);
   assign accept   = in_valid & in_ready;
   assign d_ext    = ACC_W'(in_data);
   assign cnt_next = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);

   // Operands are zero-padded to a whole number of chunks so the top chunk
   // simply truncates at ACC_W when merged back into the result.
   always_comb begin
      s_pad     = PAD_W'(s_reg);
      c_pad     = PAD_W'(c_reg);
      chunk_sum = {1'b0, s_pad[int'(ridx)*CHUNK +: CHUNK]}
                + {1'b0, c_pad[int'(ridx)*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, carry};
      sum_pad   = PAD_W'(out_sum);
      sum_pad[int'(ridx)*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
   end

   // Batch sequencing: accumulate in carry-save form, resolve one chunk per
   // cycle, then hold the result until the consumer takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ACCUM;
         s_reg     <= '0;
         c_reg     <= '0;
         count     <= '0;
         ridx      <= '0;
         carry     <= 1'b0;
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  s_reg <= s_reg ^ c_reg ^ d_ext;
                  c_reg <= ((s_reg & c_reg) | (s_reg & d_ext) | (c_reg & d_ext)) << 1;
                  count <= cnt_next;
                  if (in_last) begin
                     state     <= RESOLVE;
                     ridx      <= '0;
                     carry     <= 1'b0;
                     out_count <= cnt_next;
                     out_ovf   <= (cnt_next > CNT_W'(MAX_OPS));
                  end
               end
            end
            RESOLVE: begin
               out_sum <= sum_pad[ACC_W-1:0];
               carry   <= chunk_sum[CHUNK];
               if (ridx == RIDX_W'(NCHUNK - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  ridx      <= '0;
               end else begin
                  ridx <= ridx + RIDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  s_reg     <= '0;
                  c_reg     <= '0;
                  count     <= '0;
                  out_valid <= 1'b0;
                  state     <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: doc/csa_stream_accumulator.md
Name: csa_stream_accumulator

Overview:
- Streaming multi-operand adder. Accepts a batch of WIDTH-bit unsigned operands, one per cycle, over a valid/ready handshake.
- Keeps the running total in redundant carry-save form (sum vector S, carry vector C), so the per-operand critical path is one full-adder level regardless of batch size.
- On the batch's last operand it resolves S+C with a chunked ripple-carry adder over several cycles, then presents the result on a valid/ready output port.
- Sits between operand producers (e.g. the partial-product generator) and result consumers in the arithmetic datapath.

Parameters:
- WIDTH, 4: operand width in bits.
- MAX_OPS, 16: maximum operands per batch guaranteed exact; must be ≥2.
- CHUNK, 4: bits resolved per cycle in the final carry-propagate add.
- ACC_W (localparam), WIDTH+$clog2(MAX_OPS): accumulator and result width.
- NCHUNK (localparam), ceil(ACC_W/CHUNK): resolve cycles.
- CNT_W (localparam), $clog2(MAX_OPS)+1: operand counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand present.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  WIDTH  unsigned operand.
- in_last  input  1  qualifies in_data as the final operand of the batch.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  batch sum, mod 2^ACC_W.
- out_count  output  CNT_W  operands in the batch; saturates at 2^CNT_W-1.
- out_ovf  output  1  batch had more than MAX_OPS operands, so out_sum may have wrapped.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high. On reset, all of the following clear to 0 on the next clk edge: state, S, C, count, resolve index, chunk carry, out_valid, out_sum, out_count, out_ovf. State goes to ACCUM, so in_ready is 1 the cycle after reset deasserts. A reset during RESOLVE or DONE aborts the batch; no result is emitted.
- States: ACCUM, RESOLVE, DONE.
- ACCUM:
  - in_ready=1 and out_valid=0.
  - Accept occurs on in_valid&in_ready. Let D = zero-extend(in_data) to ACC_W. Update S <= S^C^D and C <= (maj(S,C,D))<<1, truncated to ACC_W. count <= sat(count+1).
  - Accept with in_last=1 moves to RESOLVE; otherwise stay in ACCUM.
  - in_valid=0 leaves all state unchanged.
- RESOLVE:
  - in_ready=0.
  - Cycle k (k=0..NCHUNK-1) computes bits [k*CHUNK +: CHUNK] of S+C plus the chunk-carry register, writes them into out_sum, and registers the chunk carry-out. The top chunk is truncated at ACC_W and its carry-out is discarded.
  - After chunk NCHUNK-1, go to DONE.
- DONE:
  - out_valid=1. out_sum, out_count and out_ovf are stable while out_ready=0.
  - Leave on out_valid&out_ready: clear S, C and count, then go to ACCUM. in_ready=1 on the following cycle; there is no same-cycle in-to-out bypass.
- Latency: last operand accepted at edge t. RESOLVE occupies t+1..t+NCHUNK. out_valid is high from edge t+NCHUNK. For the defaults, out_valid rises 2 cycles after the last accept.
- Throughput: one operand per cycle in ACCUM.
- out_ovf=1 iff count exceeded MAX_OPS. Accumulation continues; the result wraps mod 2^ACC_W.
- in_data and in_last are ignored when in_valid=0 or in_ready=0.
- Empty batches are impossible, because in_last only has meaning on an accepted beat.
- out_sum outside DONE is don't-care for checking.

Test Plan:
- Defaults (ACC_W=8, NCHUNK=2): operands 3,5,7,9 (in_last on 9), out_ready=1 -> out_sum=24 (0x18), out_count=4, out_ovf=0; out_valid high 2 cycles after the last accept, for exactly 1 cycle.
- 16 operands of 15 -> out_sum=240, out_count=16, out_ovf=0. The same batch with 17 operands -> out_sum=255, out_count=17, out_ovf=1.
- Single operand 0xA with in_last -> out_sum=10, out_count=1. Back-to-back batches {1,2} then {4} -> 3 then 4; the second batch must not include the first's residue.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_sum and out_count constant, in_ready=0, and in_valid pulses during those cycles are not accepted.
- in_valid gaps: 7, idle 3 cycles, 8 (last) -> out_sum=15.
- rst=1 during RESOLVE cycle 1 -> out_valid=0 and in_ready=1 after reset. A following batch {2,2} yields 4, count 2.
